// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and index type for the register-file read port
package regfile_pkg;

   localparam int RF_WIDTH    = 64;
   localparam int RF_DEPTH    = 32;
   localparam int RF_ZERO_REG = 31;
   localparam int RF_SEL_W    = $clog2(RF_DEPTH);

   typedef logic [RF_SEL_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_mux_n.sv
// rtl/regfile_mux_n.sv - DEPTH:1 by WIDTH combinational mux, zero for selects past the last register
module regfile_mux_n
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   parameter int SEL_W = $clog2(DEPTH)
) (
   input  logic [DEPTH*WIDTH-1:0] rf_data,
   input  logic [SEL_W-1:0]       sel,
   output logic [WIDTH-1:0]       data
);

   // Non-power-of-two depths leave some select codes unmatched, which fall through to zero.
   always_comb begin
      data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sel == SEL_W'(k)) begin
            data = rf_data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - registered register-file read port with zero reg, forwarding and handshake
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter int SEL_W    = $clog2(DEPTH),
   parameter int ZERO_EN  = 1,
   parameter int ZERO_REG = RF_ZERO_REG
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [DEPTH*WIDTH-1:0] rf_data,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [SEL_W-1:0]       req_sel,
   input  logic                   wr_en,
   input  logic [SEL_W-1:0]       wr_sel,
   input  logic [WIDTH-1:0]       wr_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_err
);

   localparam logic [SEL_W:0]   DEPTH_LIM   = (SEL_W+1)'(DEPTH);
   localparam bit               ZERO_ACTIVE = (ZERO_EN != 0) && (ZERO_REG < DEPTH);
   localparam logic [SEL_W-1:0] ZERO_IDX    = SEL_W'(ZERO_REG);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             out_err_q,   out_err_d;

   logic [WIDTH-1:0] mux_data;
   logic [WIDTH-1:0] rd_data;
   logic             sel_oob;
   logic             accept;

   regfile_mux_n #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
   ) u_mux (
      .rf_data (rf_data),
      .sel     (req_sel),
      .data    (mux_data)
   );

   // Result priority: out-of-range, then zero register, then same-cycle write, then storage.
   always_comb begin
      sel_oob = ({1'b0, req_sel} >= DEPTH_LIM);
      rd_data = mux_data;
      if (sel_oob) begin
         rd_data = '0;
      end else if (ZERO_ACTIVE && (req_sel == ZERO_IDX)) begin
         rd_data = '0;
      end else if (wr_en && (wr_sel == req_sel)) begin
         rd_data = wr_data;
      end
   end

   always_comb begin
      req_ready   = !out_valid_q || out_ready;
      accept      = req_valid && req_ready;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = rd_data;
         out_err_d   = sel_oob;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// tb/tb_regfile_read_port.sv - directed bench for regfile_read_port at depths 32 and 24
module tb_regfile_read_port;
   import regfile_pkg::*;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             req_valid;
   reg_idx_t         req_sel;
   logic             wr_en;
   reg_idx_t         wr_sel;
   logic [63:0]      wr_data;
   logic             out_ready;
   logic [63:0]      rf [0:31];
   logic [32*64-1:0] rf_data32;
   logic [24*64-1:0] rf_data24;

   logic             rr32, ov32, oe32;
   logic [63:0]      od32;
   logic             rr24, ov24, oe24;
   logic [63:0]      od24;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always_comb begin
      rf_data32 = '0;
      for (int k = 0; k < 32; k++) rf_data32[k*64 +: 64] = rf[k];
      rf_data24 = rf_data32[24*64-1:0];
   end

   regfile_read_port u_dut32 (
      .clk (clk), .reset_n (reset_n), .rf_data (rf_data32),
      .req_valid (req_valid), .req_ready (rr32), .req_sel (req_sel),
      .wr_en (wr_en), .wr_sel (wr_sel), .wr_data (wr_data),
      .out_valid (ov32), .out_ready (out_ready), .out_data (od32), .out_err (oe32)
   );

   regfile_read_port #(.DEPTH(24)) u_dut24 (
      .clk (clk), .reset_n (reset_n), .rf_data (rf_data24),
      .req_valid (req_valid), .req_ready (rr24), .req_sel (req_sel),
      .wr_en (wr_en), .wr_sel (wr_sel), .wr_data (wr_data),
      .out_valid (ov24), .out_ready (out_ready), .out_data (od24), .out_err (oe24)
   );

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: one result slot per instance, index 0 = depth 32, index 1 = depth 24.
   int          depth_of [2] = '{32, 24};
   logic        m_valid  [2];
   logic [63:0] m_data   [2];
   logic        m_err    [2];

   function automatic void read_rule(input int depth, input int sel,
                                     output logic [63:0] d, output logic e);
      e = 1'b0;
      if (sel >= depth) begin
         d = 64'h0;
         e = 1'b1;
      end else if (sel == 31)              d = 64'h0;
      else if (wr_en && int'(wr_sel) == sel) d = wr_data;
      else                                  d = rf[sel];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 64'h0;
            m_err[i]   = 1'b0;
         end else if (req_valid && (!m_valid[i] || out_ready)) begin
            m_valid[i] = 1'b1;
            read_rule(depth_of[i], int'(req_sel), m_data[i], m_err[i]);
         end else if (m_valid[i] && out_ready) begin
            m_valid[i] = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      cmp("model_valid32", {63'h0, ov32}, {63'h0, m_valid[0]});
      cmp("model_data32",  od32, m_data[0]);
      cmp("model_err32",   {63'h0, oe32}, {63'h0, m_err[0]});
      cmp("model_ready32", {63'h0, rr32}, {63'h0, !m_valid[0] || out_ready});
      cmp("model_valid24", {63'h0, ov24}, {63'h0, m_valid[1]});
      cmp("model_data24",  od24, m_data[1]);
      cmp("model_err24",   {63'h0, oe24}, {63'h0, m_err[1]});
      cmp("model_ready24", {63'h0, rr24}, {63'h0, !m_valid[1] || out_ready});
   end

   task automatic cyc();
      @(posedge clk);
      #3;
   endtask

   initial begin
      for (int k = 0; k < 32; k++) rf[k] = 64'h1000 + 64'(k);
      reset_n   = 1'b0;
      req_valid = 1'b1;
      req_sel   = 5'd5;
      out_ready = 1'b0;
      wr_en     = 1'b0;
      wr_sel    = 5'd0;
      wr_data   = 64'h0;

      for (int c = 0; c < 2; c++) begin
         cyc();
         cmp("rst_valid", {63'h0, ov32}, 64'h0);
         cmp("rst_data",  od32, 64'h0);
         @(negedge clk);
      end

      reset_n   = 1'b1;
      out_ready = 1'b1;
      cyc();
      cmp("read5_valid", {63'h0, ov32}, 64'h1);
      cmp("read5_data",  od32, 64'h1005);
      cmp("read5_err",   {63'h0, oe32}, 64'h0);

      @(negedge clk);
      rf[31]  = '1;
      wr_en   = 1'b1;
      wr_sel  = 5'd31;
      wr_data = 64'hDEAD;
      req_sel = 5'd31;
      cyc();
      cmp("zero_data", od32, 64'h0);
      cmp("zero_err",  {63'h0, oe32}, 64'h0);
      cmp("zero_err24", {63'h0, oe24}, 64'h1);

      @(negedge clk);
      wr_sel  = 5'd7;
      wr_data = 64'hBEEF;
      req_sel = 5'd7;
      cyc();
      cmp("fwd_hit", od32, 64'hBEEF);

      @(negedge clk);
      wr_sel = 5'd8;
      cyc();
      cmp("fwd_miss", od32, 64'h1007);

      @(negedge clk);
      wr_en   = 1'b0;
      req_sel = 5'd3;
      cyc();
      cmp("bp_load", od32, 64'h1003);

      @(negedge clk);
      out_ready = 1'b0;
      req_sel   = 5'd9;
      rf[3]     = 64'h0;
      for (int c = 0; c < 4; c++) begin
         cyc();
         cmp("bp_hold_data",  od32, 64'h1003);
         cmp("bp_hold_ready", {63'h0, rr32}, 64'h0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      req_sel   = 5'd4;
      cyc();
      cmp("bp_release", od32, 64'h1004);
      cmp("bp_release_valid", {63'h0, ov32}, 64'h1);

      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         req_sel = reg_idx_t'(k);
         cyc();
         cmp("stream_valid24", {63'h0, ov24}, 64'h1);
         cmp("stream_data24", od24, (k == 3) ? 64'h0 : 64'h1000 + 64'(k));
      end

      @(negedge clk);
      req_sel = 5'd30;
      cyc();
      cmp("oob_data24", od24, 64'h0);
      cmp("oob_err24",  {63'h0, oe24}, 64'h1);
      cmp("inrange_data32", od32, 64'h101E);
      cmp("inrange_err32",  {63'h0, oe32}, 64'h0);

      @(negedge clk);
      req_sel = 5'd6;
      cyc();
      @(negedge clk);
      out_ready = 1'b0;
      req_valid = 1'b0;
      cyc();
      cmp("hold6_data", od32, 64'h1006);

      @(negedge clk);
      reset_n = 1'b0;
      cyc();
      cmp("midrst_valid", {63'h0, ov32}, 64'h0);
      cmp("midrst_data",  od32, 64'h0);
      cmp("midrst_err",   {63'h0, oe24}, 64'h0);
      cmp("midrst_ready", {63'h0, rr32}, 64'h1);

      @(negedge clk);
      reset_n = 1'b1;
      cyc();
      cmp("idle_valid", {63'h0, ov32}, 64'h0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Parametrised, registered read port for the CPU register file. Generalises the fixed 8:1 single-bit mux to an N-entry by WIDTH-bit select.
- Adds an output pipeline register with a valid/ready handshake, a hard-wired zero register, write-to-read forwarding and out-of-range select detection.
- Sits between the register storage array and the decode/operand-fetch stage. One instance per read port.

Parameters:
- WIDTH, 64, data width of each register in bits
- DEPTH, 32, number of registers; need not be a power of two
- SEL_W, $clog2(DEPTH), select/address width (derived; do not override)
- ZERO_EN, 1, 1 = register ZERO_REG always reads as 0
- ZERO_REG, 31, index of the hard-wired zero register (used only when ZERO_EN=1)

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset_n  input  1  synchronous, active-low reset
- rf_data  input  DEPTH*WIDTH  flattened register contents; register k occupies bits [k*WIDTH +: WIDTH]
- req_valid  input  1  read request valid
- req_ready  output  1  port can accept a request this cycle
- req_sel  input  SEL_W  register index to read
- wr_en  input  1  same-cycle register-file write enable (forwarding source)
- wr_sel  input  SEL_W  register index being written
- wr_data  input  WIDTH  data being written
- out_valid  output  1  out_data/out_err hold a valid result
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  registered read data
- out_err  output  1  registered flag: req_sel was >= DEPTH

Behaviour:
- Reset: while reset_n=0 at a rising edge: out_valid=0, out_data=0, out_err=0. Reset overrides any handshake in the same cycle. A reset mid-transfer discards the held result.
- req_ready = !out_valid || out_ready. This is combinational, with a single output register and no skid buffer.
- Accept: req_valid && req_ready at a rising edge. Latency is 1 cycle: out_valid=1 on the next cycle, carrying the result for the req_sel sampled at accept.
- Result selection, highest priority first:
  1. req_sel >= DEPTH: out_data=0, out_err=1.
  2. ZERO_EN && req_sel==ZERO_REG: out_data=0, out_err=0. Writes to ZERO_REG are never forwarded.
  3. wr_en && wr_sel==req_sel: out_data=wr_data, out_err=0 (forwarding).
  4. Otherwise: out_data=rf_data[req_sel], out_err=0.
- Hold (out_valid && !out_ready): out_data and out_err stay stable. They do not track later changes to rf_data or wr_*.
- Drain (out_valid && out_ready && !req_valid): out_valid goes to 0 on the next edge; out_data keeps its last value.
- Back-to-back (out_valid && out_ready && req_valid): the new result is loaded on the same edge. Sustained throughput is 1 read per cycle.
- No req_valid while idle: no state change.
- Bus ordering: select is by index, not by bit order. Index 0 is the LSB slice of rf_data.
- Purely synchronous. No latches. No combinational path from rf_data or wr_* to any output.

Decomposition:
- Package regfile_pkg holds:
  - default WIDTH and DEPTH constants
  - the ZERO_REG constant
  - a typedef reg_idx_t for the SEL_W-bit index
- One sub-module, regfile_mux_n: combinational parametrised DEPTH:1 by WIDTH mux that returns 0 for out-of-range selects.
- regfile_read_port instantiates regfile_mux_n once and adds the priority, forwarding and handshake register logic.

Test Plan:
- Reset and basic read:
  - Stimulus: reset_n=0 for 2 cycles with req_valid=1.
  - Response: out_valid=0 and out_data=0 throughout.
  - Stimulus: release reset; load rf_data with reg k = 64'h1000+k; request sel=5.
  - Response: next cycle out_valid=1, out_data=64'h1005, out_err=0.
- Zero register:
  - Stimulus: rf_data reg31 = all-ones, wr_en=1, wr_sel=31, wr_data=64'hDEAD; request sel=31.
  - Response: out_data=0, out_err=0.
- Forwarding:
  - Stimulus: reg 7 = 64'h1007, wr_en=1, wr_sel=7, wr_data=64'hBEEF; request sel=7.
  - Response: out_data=64'hBEEF.
  - Stimulus: same, but wr_sel=8.
  - Response: out_data=64'h1007.
- Backpressure:
  - Stimulus: accept sel=3, hold out_ready=0 for 4 cycles while changing rf_data reg3 to 64'h0.
  - Response: out_data stays 64'h1003, req_ready=0 each held cycle.
  - Stimulus: set out_ready=1 with a new request sel=4 in the same cycle.
  - Response: next cycle out_data=64'h1004. No bubble.
- Streaming and out-of-range:
  - Stimulus: DEPTH=24 build; requests sel=0..23 back-to-back with out_ready=1.
  - Response: one result per cycle, in order.
  - Stimulus: request sel=30.
  - Response: out_data=0, out_err=1.
- Reset mid-hold:
  - Stimulus: reset_n=0 for one cycle while out_valid=1 and out_ready=0.
  - Response: next cycle out_valid=0, out_data=0, out_err=0, req_ready=1.
